// File: rtl/conv1d_seq_ctrl.sv
// Conv1d layer sequencer: loads kernel weights + bias from a ROM into the conv engine,
// then runs N_OUT operations, streaming samples in and forwarding results downstream.
module conv1d_seq_ctrl #(
    parameter int unsigned DW     = 32,
    parameter int unsigned size_k = 3,
    parameter int unsigned stride = 1,
    parameter int unsigned N_OUT  = 93,
    parameter int unsigned AW     = 4
) (
    input  logic          clk,
    input  logic          RSTn,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_w_addr,
    input  logic [DW-1:0] i_w_data,
    output logic          o_EN_w,
    output logic          o_EN_c,
    input  logic          i_cv_busy,
    output logic [DW-1:0] o_cv_data,
    output logic          o_cv_stb,
    input  logic          i_cv_ack,
    input  logic [DW-1:0] i_cv_data,
    input  logic          i_cv_stb,
    output logic          o_cv_ack,
    input  logic [DW-1:0] i_x_data,
    input  logic          i_x_stb,
    output logic          o_x_ack,
    output logic [DW-1:0] o_y_data,
    output logic          o_y_stb,
    input  logic          i_y_ack
);

    localparam int unsigned OCW = $clog2(N_OUT) + 1;
    localparam int unsigned SCW = $clog2(stride + 1) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_W_ADDR, S_W_EN, S_W_PUT, S_W_END,
        S_C_EN, S_X_FWD, S_R_WAIT, S_Y_OUT
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wc_q, wc_d;
    logic [OCW-1:0]  oc_q, oc_d;
    logic [SCW-1:0]  sc_q, sc_d;
    logic            sess_q, sess_d;
    logic            en_w_q, en_w_d;
    logic            en_c_q, en_c_d;
    logic            done_q, done_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic [DW-1:0]   y_q, y_d;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            wc_q     <= '0;
            oc_q     <= '0;
            sc_q     <= '0;
            sess_q   <= 1'b0;
            en_w_q   <= 1'b0;
            en_c_q   <= 1'b0;
            done_q   <= 1'b0;
            w_data_q <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            wc_q     <= wc_d;
            oc_q     <= oc_d;
            sc_q     <= sc_d;
            sess_q   <= sess_d;
            en_w_q   <= en_w_d;
            en_c_q   <= en_c_d;
            done_q   <= done_d;
            w_data_q <= w_data_d;
            y_q      <= y_d;
        end
    end

    // Next state and stream muxing; X_FWD is a pure combinational pass-through.
    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        oc_d      = oc_q;
        sc_d      = sc_q;
        sess_d    = sess_q;
        en_w_d    = en_w_q;
        en_c_d    = en_c_q;
        done_d    = 1'b0;
        w_data_d  = w_data_q;
        y_d       = y_q;
        o_cv_data = '0;
        o_cv_stb  = 1'b0;
        o_x_ack   = 1'b0;
        o_cv_ack  = 1'b0;
        o_y_stb   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_W_ADDR;
                    wc_d    = '0;
                    oc_d    = '0;
                    sess_d  = 1'b0;
                end
            end
            S_W_ADDR: state_d = S_W_EN;
            S_W_EN: begin
                // ROM data for wc is valid here; the engine is enabled once per load session
                w_data_d = i_w_data;
                if (sess_q) begin
                    state_d = S_W_PUT;
                end else if (!en_w_q) begin
                    if (!i_cv_busy) en_w_d = 1'b1;
                end else if (i_cv_busy) begin
                    en_w_d  = 1'b0;
                    sess_d  = 1'b1;
                    state_d = S_W_PUT;
                end
            end
            S_W_PUT: begin
                o_cv_data = w_data_q;
                o_cv_stb  = 1'b1;
                if (i_cv_ack) begin
                    if (wc_q == AW'(size_k)) begin
                        state_d = S_W_END;
                    end else begin
                        wc_d    = wc_q + AW'(1);
                        state_d = S_W_ADDR;
                    end
                end
            end
            S_W_END: begin
                if (!i_cv_busy) state_d = S_C_EN;
            end
            S_C_EN: begin
                if (!en_c_q) begin
                    if (!i_cv_busy) en_c_d = 1'b1;
                end else if (i_cv_busy) begin
                    en_c_d  = 1'b0;
                    sc_d    = '0;
                    state_d = S_X_FWD;
                end
            end
            S_X_FWD: begin
                o_cv_data = i_x_data;
                o_cv_stb  = i_x_stb;
                o_x_ack   = i_cv_ack;
                if (i_x_stb && i_cv_ack) begin
                    sc_d = sc_q + SCW'(1);
                    if (sc_q == SCW'(stride)) state_d = S_R_WAIT;
                end
            end
            S_R_WAIT: begin
                o_cv_ack = 1'b1;
                if (i_cv_stb) begin
                    y_d     = i_cv_data;
                    state_d = S_Y_OUT;
                end
            end
            S_Y_OUT: begin
                o_y_stb = 1'b1;
                if (i_y_ack) begin
                    if (oc_q == OCW'(N_OUT - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        oc_d    = oc_q + OCW'(1);
                        state_d = S_C_EN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = done_q;
    assign o_w_addr = wc_q;
    assign o_EN_w   = en_w_q;
    assign o_EN_c   = en_c_q;
    assign o_y_data = y_q;

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
// Randomized bench for conv1d_seq_ctrl: ROM, engine, upstream and downstream models
// plus a reference that derives expected results directly from ROM contents and samples.
module tb_conv1d_seq_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned SK = 3;
    localparam int unsigned ST = 1;
    localparam int unsigned NO = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned NS = NO * (ST + 1);

    logic          clk = 1'b0;
    logic          RSTn;
    logic          i_start;
    logic          o_busy, o_done, o_EN_w, o_EN_c;
    logic [AW-1:0] o_w_addr;
    logic [DW-1:0] i_w_data;
    logic          i_cv_busy;
    logic [DW-1:0] o_cv_data;
    logic          o_cv_stb, i_cv_ack;
    logic [DW-1:0] i_cv_data;
    logic          i_cv_stb, o_cv_ack;
    logic [DW-1:0] i_x_data;
    logic          i_x_stb, o_x_ack;
    logic [DW-1:0] o_y_data;
    logic          o_y_stb, i_y_ack;

    always #5 clk = ~clk;

    conv1d_seq_ctrl #(.DW(DW), .size_k(SK), .stride(ST), .N_OUT(NO), .AW(AW)) dut (
        .clk(clk), .RSTn(RSTn), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_w_addr(o_w_addr), .i_w_data(i_w_data), .o_EN_w(o_EN_w), .o_EN_c(o_EN_c),
        .i_cv_busy(i_cv_busy), .o_cv_data(o_cv_data), .o_cv_stb(o_cv_stb),
        .i_cv_ack(i_cv_ack), .i_cv_data(i_cv_data), .i_cv_stb(i_cv_stb),
        .o_cv_ack(o_cv_ack), .i_x_data(i_x_data), .i_x_stb(i_x_stb), .o_x_ack(o_x_ack),
        .o_y_data(o_y_data), .o_y_stb(o_y_stb), .i_y_ack(i_y_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] conv_ref(input logic [31:0] w0, w1, w2, b, s0, s1);
        return b + w0 * s0 + w1 * s1 + w2 * (s0 ^ s1);
    endfunction

    logic [31:0] rom [16];
    logic [31:0] xq[$];
    logic [31:0] yexp[$];
    logic [31:0] eng_w [SK+1];
    logic [31:0] eng_s [ST+1];
    logic [31:0] eng_res;
    logic [31:0] y_hold;
    int eng_st, eng_cnt;
    int load_cnt, x_cnt, y_cnt, done_cnt;
    int stall_idx, stall_left;
    bit stall_done, gap_mode;

    logic          s_en_w, s_en_c, s_cvx, s_rx, s_xx, s_yx, s_ystb;
    logic [31:0]   s_cvd, s_yd;
    logic [AW-1:0] s_addr;

    // Environment: sample handshakes at negedge, apply effects and new inputs just after posedge
    initial begin
        i_w_data = '0; i_cv_busy = 1'b0; i_cv_ack = 1'b0; i_cv_data = '0; i_cv_stb = 1'b0;
        i_x_data = '0; i_x_stb = 1'b0; i_y_ack = 1'b0;
        eng_st = 0; eng_cnt = 0; eng_res = '0; stall_left = 0; y_hold = '0;
        forever begin
            @(negedge clk);
            s_en_w = o_EN_w; s_en_c = o_EN_c;
            s_cvx  = o_cv_stb && i_cv_ack; s_cvd = o_cv_data;
            s_rx   = i_cv_stb && o_cv_ack;
            s_xx   = i_x_stb && o_x_ack;
            s_yx   = o_y_stb && i_y_ack; s_yd = o_y_data; s_ystb = o_y_stb;
            s_addr = o_w_addr;
            if (RSTn && o_done) begin
                done_cnt++;
                check("busy_low_at_done", 32'(o_busy), 32'd0);
            end
            @(posedge clk); #1;
            if (!RSTn) begin
                eng_st = 0; xq.delete(); yexp.delete(); stall_left = 0;
                i_cv_busy = 1'b0; i_cv_ack = 1'b0; i_cv_stb = 1'b0;
                i_x_stb = 1'b0; i_y_ack = 1'b0;
            end else begin
                i_w_data = rom[s_addr];
                case (eng_st)
                    0: begin
                        if (s_en_w) begin eng_st = 1; eng_cnt = 0; end
                        else if (s_en_c) begin eng_st = 2; eng_cnt = 0; end
                    end
                    1: if (s_cvx) begin
                        check($sformatf("wload%0d", eng_cnt), s_cvd, rom[eng_cnt]);
                        eng_w[eng_cnt] = s_cvd;
                        eng_cnt++; load_cnt++;
                        if (eng_cnt == SK + 1) eng_st = 0;
                    end
                    2: if (s_cvx) begin
                        eng_s[eng_cnt] = s_cvd;
                        eng_cnt++;
                        if (eng_cnt == ST + 1) begin
                            eng_st  = 3;
                            eng_res = conv_ref(eng_w[0], eng_w[1], eng_w[2], eng_w[3],
                                               eng_s[0], eng_s[1]);
                        end
                    end
                    3: if (s_rx) eng_st = 0;
                    default: eng_st = 0;
                endcase
                i_cv_busy = (eng_st != 0);
                i_cv_ack  = (eng_st == 1 || eng_st == 2) && ($urandom_range(3) != 0);
                i_cv_stb  = (eng_st == 3);
                i_cv_data = (eng_st == 3) ? eng_res : 32'hA5A5_0000 + 32'($urandom_range(255));

                if (s_xx) begin
                    if (xq.size() > 0) void'(xq.pop_front());
                    x_cnt++;
                end
                if (!i_x_stb || s_xx) begin
                    i_x_stb  = (xq.size() > 0) && (!gap_mode || $urandom_range(2) == 0);
                    i_x_data = (xq.size() > 0) ? xq[0] : 32'($urandom);
                end

                if (s_yx) begin
                    check($sformatf("y%0d", y_cnt), s_yd,
                          (yexp.size() > 0) ? yexp.pop_front() : 32'hDEAD_BEEF);
                    y_cnt++;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    check("stall_y_stb", 32'(s_ystb), 32'd1);
                    check("stall_y_data", s_yd, y_hold);
                    check("stall_no_x_ack", 32'(s_xx), 32'd0);
                end else if (s_ystb && !s_yx && y_cnt == stall_idx && !stall_done) begin
                    stall_left = 20;
                    stall_done = 1'b1;
                    y_hold     = s_yd;
                end
                i_y_ack = (stall_left == 0) && !(y_cnt == stall_idx && !stall_done) &&
                          ($urandom_range(3) != 0);
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   32'(o_busy),   32'd0);
        check({tag, "_done"},   32'(o_done),   32'd0);
        check({tag, "_en_w"},   32'(o_EN_w),   32'd0);
        check({tag, "_en_c"},   32'(o_EN_c),   32'd0);
        check({tag, "_cv_stb"}, 32'(o_cv_stb), 32'd0);
        check({tag, "_cv_ack"}, 32'(o_cv_ack), 32'd0);
        check({tag, "_x_ack"},  32'(o_x_ack),  32'd0);
        check({tag, "_y_stb"},  32'(o_y_stb),  32'd0);
        check({tag, "_y_data"}, o_y_data,      32'd0);
        check({tag, "_cv_data"}, o_cv_data,    32'd0);
        check({tag, "_w_addr"}, 32'(o_w_addr), 32'd0);
    endtask

    // Fresh ROM / sample set and the expected result sequence from the reference
    task automatic setup(input bit fixed);
        logic [31:0] s [NS];
        for (int i = 0; i < 16; i++) rom[i] = $urandom;
        if (fixed) begin
            rom[0] = 32'd2; rom[1] = 32'd3; rom[2] = 32'd4; rom[3] = 32'd10;
        end
        for (int i = 0; i < NS; i++) s[i] = fixed ? 32'(i) : $urandom;
        xq.delete(); yexp.delete();
        for (int i = 0; i < NS; i++) xq.push_back(s[i]);
        for (int k = 0; k < NO; k++)
            yexp.push_back(conv_ref(rom[0], rom[1], rom[2], rom[3], s[2*k], s[2*k+1]));
        load_cnt = 0; x_cnt = 0; y_cnt = 0; done_cnt = 0;
        stall_done = 1'b0; stall_left = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); #2;
        i_start = 1'b1;
        @(negedge clk); #2;
        i_start = 1'b0;
    endtask

    task automatic run(input string tag, input bit fixed, input bit gaps, input int stall);
        int t;
        @(negedge clk); #2;
        setup(fixed);
        gap_mode  = gaps;
        stall_idx = stall;
        pulse_start();
        repeat (15) @(negedge clk);
        #2;
        i_start = 1'b1;
        @(negedge clk); #2;
        i_start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_loads"},    32'(load_cnt), 32'(SK + 1));
        check({tag, "_samples"},  32'(x_cnt),    32'(NS));
        check({tag, "_results"},  32'(y_cnt),    32'(NO));
        check({tag, "_pending"},  32'(yexp.size()), 32'd0);
        check({tag, "_busy_end"}, 32'(o_busy),   32'd0);
    endtask

    initial begin
        int t;
        RSTn = 1'b0; i_start = 1'b0; gap_mode = 1'b0; stall_idx = -1;
        load_cnt = 0; x_cnt = 0; y_cnt = 0; done_cnt = 0; stall_done = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        check_idle("rst");
        #2 RSTn = 1'b1;

        run("ramp",   1'b1, 1'b0, -1);
        run("rand",   1'b0, 1'b0, -1);
        run("stall",  1'b0, 1'b0, 1);
        run("gaps",   1'b1, 1'b1, -1);
        run("gapstl", 1'b0, 1'b1, 2);

        // Reset after the first sample of the first operation
        @(negedge clk); #2;
        setup(1'b0);
        gap_mode = 1'b0; stall_idx = -1;
        pulse_start();
        t = 0;
        while (x_cnt < 1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("mid_x_reached", 32'(x_cnt), 32'd1);
        #2 RSTn = 1'b0;
        #1 check_idle("midrst");
        repeat (2) @(negedge clk);
        #2 RSTn = 1'b1;
        run("post_rst", 1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
